// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/interrupt sequencer in front of the CSR file.
// On an exception or enabled interrupt it stalls the core, writes
// mepc/mcause/mtval/mstatus one per cycle, then jumps to mtvec.
// On mret it restores mstatus and jumps to mepc.
// Optional feature: define TRAP_VECTORED_EN for vectored interrupt entry
// (mtvec[1:0]==2'b01 -> base + 4*cause for interrupts).

`ifndef CSR_MSTATUS
`define CSR_MSTATUS 12'h300
`endif
`ifndef CSR_MTVEC
`define CSR_MTVEC   12'h305
`endif
`ifndef CSR_MEPC
`define CSR_MEPC    12'h341
`endif
`ifndef CSR_MCAUSE
`define CSR_MCAUSE  12'h342
`endif
`ifndef CSR_MTVAL
`define CSR_MTVAL   12'h343
`endif

module trap_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_pc_i,
    input  logic [31:0] inst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        ex_trap_i,
    input  logic        soft_trap_i,
    input  logic        tcmp_trap_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mepc_i,
    output logic        trap_csr_we_o,
    output logic [11:0] trap_csr_addr_o,
    output logic [31:0] trap_csr_wdata_o,
    input  logic [31:0] trap_csr_rdata_i,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MTVAL,
        W_MSTATUS,
        JUMP_TVEC,
        R_MSTATUS,
        JUMP_EPC
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_exc_illegal;
    logic        w_exc_ecall;
    logic        w_exc_ebreak;
    logic        w_mret;
    logic        w_int_ext;
    logic        w_int_soft;
    logic        w_int_tcmp;
    logic        w_exc;
    logic        w_int;
    logic        w_idle;
    logic        w_req;
    logic [31:0] w_cause;
    logic [31:0] w_mtval;
    logic [31:0] w_tvec_base;
    logic [31:0] w_target;

    logic [31:0] r_cause;
    logic [31:0] r_pc;
    logic [31:0] r_mtval;
    logic [31:0] r_jump_addr;

    assign w_exc_illegal = inst_valid_i & illegal_i;
    assign w_exc_ecall   = inst_valid_i & ecall_i;
    assign w_exc_ebreak  = inst_valid_i & ebreak_i;
    assign w_mret        = inst_valid_i & mret_i;
    assign w_int_ext     = inst_valid_i & mstatus_mie_i & ex_trap_i;
    assign w_int_soft    = inst_valid_i & mstatus_mie_i & soft_trap_i;
    assign w_int_tcmp    = inst_valid_i & mstatus_mie_i & tcmp_trap_i;

    assign w_exc  = w_exc_illegal | w_exc_ecall | w_exc_ebreak;
    assign w_int  = w_int_ext | w_int_soft | w_int_tcmp;
    assign w_idle = (r_state == IDLE);
    assign w_req  = w_idle & (w_exc | w_mret | w_int);

    assign busy_o      = ~w_idle;
    assign hold_o      = busy_o | w_req;
    assign jump_addr_o = jump_o ? w_target : r_jump_addr;

    // Prioritised cause / trap value for the request seen in IDLE
    always_comb begin
        w_cause = '0;
        w_mtval = '0;
        if (w_exc_illegal) begin
            w_cause = 32'd2;
            w_mtval = inst_i;
        end else if (w_exc_ecall) begin
            w_cause = 32'd11;
        end else if (w_exc_ebreak) begin
            w_cause = 32'd3;
            w_mtval = inst_pc_i;
        end else if (w_int_ext) begin
            w_cause = 32'h8000_000B;
        end else if (w_int_soft) begin
            w_cause = 32'h8000_0003;
        end else if (w_int_tcmp) begin
            w_cause = 32'h8000_0007;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch cause, pc and trap value when a request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= '0;
            r_pc    <= '0;
            r_mtval <= '0;
        end else if (w_req) begin
            r_cause <= w_cause;
            r_pc    <= inst_pc_i;
            r_mtval <= w_mtval;
        end
    end

    // Last redirect target, held between jumps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jump_addr <= RESET_VEC;
        end else if (jump_o) begin
            r_jump_addr <= w_target;
        end
    end

    // Next-state logic; mret outranks interrupts but not exceptions
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_exc) begin
                    w_next = W_MEPC;
                end else if (w_mret) begin
                    w_next = R_MSTATUS;
                end else if (w_int) begin
                    w_next = W_MEPC;
                end
            end
            W_MEPC:    w_next = W_MCAUSE;
            W_MCAUSE:  w_next = W_MTVAL;
            W_MTVAL:   w_next = W_MSTATUS;
            W_MSTATUS: w_next = JUMP_TVEC;
            JUMP_TVEC: w_next = IDLE;
            R_MSTATUS: w_next = JUMP_EPC;
            JUMP_EPC:  w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // CSR channel and jump strobe per state
    always_comb begin
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = '0;
        trap_csr_wdata_o = '0;
        jump_o           = 1'b0;
        case (r_state)
            W_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = `CSR_MEPC;
                trap_csr_wdata_o = r_pc;
            end
            W_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = `CSR_MCAUSE;
                trap_csr_wdata_o = r_cause;
            end
            W_MTVAL: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = `CSR_MTVAL;
                trap_csr_wdata_o = r_mtval;
            end
            W_MSTATUS: begin
                trap_csr_we_o       = 1'b1;
                trap_csr_addr_o     = `CSR_MSTATUS;
                trap_csr_wdata_o[7] = trap_csr_rdata_i[3];
            end
            JUMP_TVEC: begin
                trap_csr_addr_o = `CSR_MTVEC;
                jump_o          = 1'b1;
            end
            R_MSTATUS: begin
                trap_csr_we_o       = 1'b1;
                trap_csr_addr_o     = `CSR_MSTATUS;
                trap_csr_wdata_o[7] = 1'b1;
                trap_csr_wdata_o[3] = trap_csr_rdata_i[7];
            end
            JUMP_EPC: begin
                jump_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Redirect target: mtvec base (optionally vectored) or mepc
    always_comb begin
        w_tvec_base = {trap_csr_rdata_i[31:2], 2'b00};
        w_target    = w_tvec_base;
`ifdef TRAP_VECTORED_EN
        if (trap_csr_rdata_i[1:0] == 2'b01 && r_cause[31]) begin
            w_target = w_tvec_base + {25'b0, r_cause[4:0], 2'b00};
        end
`endif
        if (r_state == JUMP_EPC) begin
            w_target = mepc_i;
        end
    end

endmodule
